// File: rtl/spin_readout.sv
// Spin readout for the coupled-oscillator array: synchronise each oscillator and the
// reference, count phase mismatches over a fixed window, majority-decide one spin per lane.
module spin_readout #(
   parameter int N           = 8,
   parameter int SAMPLE_BITS = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] osc_in,
   input  logic         ref_in,
   input  logic         start,
   output logic         ready,
   output logic [N-1:0] spins_out,
   output logic         spins_valid,
   input  logic         spins_ack
);

   localparam int SETTLE_W = (SYNC_STAGES > 1) ? $clog2(SYNC_STAGES) : 1;
   localparam logic [SETTLE_W-1:0]    SETTLE_LAST = SETTLE_W'(SYNC_STAGES - 1);
   localparam logic [SAMPLE_BITS-1:0] SAMPLE_LAST = '1;
   localparam logic [SAMPLE_BITS:0]   HALF        = (SAMPLE_BITS + 1)'(2 ** (SAMPLE_BITS - 1));

   typedef enum logic [2:0] {
      IDLE,
      SETTLE,
      SAMPLE,
      DECIDE,
      HOLD
   } state_t;

   state_t state_reg, state_next;

   // Bit N of every stage carries the reference, bits N-1:0 the oscillators.
   logic [N:0]             sync_reg [SYNC_STAGES];
   logic [N-1:0]           osc_s;
   logic                   ref_s;

   logic [SETTLE_W-1:0]    settle_cnt_reg;
   logic [SAMPLE_BITS-1:0] sample_cnt_reg;
   logic [SAMPLE_BITS:0]   cnt_reg  [N];
   logic [SAMPLE_BITS:0]   cnt_next [N];
   logic [N-1:0]           decision;
   logic [N-1:0]           spins_out_reg;

   assign osc_s = sync_reg[SYNC_STAGES-1][N-1:0];
   assign ref_s = sync_reg[SYNC_STAGES-1][N];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            sync_reg[s] <= '0;
         end
      end else begin
         sync_reg[0] <= {ref_in, osc_in};
         for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_reg[s] <= sync_reg[s-1];
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_lane
         logic mismatch;
         assign mismatch     = osc_s[gi] ^ ref_s;
         assign cnt_next[gi] = cnt_reg[gi] + {{SAMPLE_BITS{1'b0}}, mismatch};
         // Strictly more than half the window: an exact tie reads as in-phase.
         assign decision[gi] = (cnt_reg[gi] > HALF);
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = SETTLE;
            end
         end
         SETTLE: begin
            if (settle_cnt_reg == SETTLE_LAST) begin
               state_next = SAMPLE;
            end
         end
         SAMPLE: begin
            if (sample_cnt_reg == SAMPLE_LAST) begin
               state_next = DECIDE;
            end
         end
         DECIDE: begin
            state_next = HOLD;
         end
         HOLD: begin
            if (spins_ack) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         settle_cnt_reg <= '0;
         sample_cnt_reg <= '0;
         spins_out_reg  <= '0;
         for (int i = 0; i < N; i++) begin
            cnt_reg[i] <= '0;
         end
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  settle_cnt_reg <= '0;
                  sample_cnt_reg <= '0;
                  for (int i = 0; i < N; i++) begin
                     cnt_reg[i] <= '0;
                  end
               end
            end
            SETTLE: begin
               settle_cnt_reg <= settle_cnt_reg + SETTLE_W'(1);
            end
            SAMPLE: begin
               // Wraps back to zero on the last window cycle, ready for the next run.
               sample_cnt_reg <= sample_cnt_reg + SAMPLE_BITS'(1);
               for (int i = 0; i < N; i++) begin
                  cnt_reg[i] <= cnt_next[i];
               end
            end
            DECIDE: begin
               spins_out_reg <= decision;
            end
            default: begin
            end
         endcase
      end
   end

   assign ready       = (state_reg == IDLE);
   assign spins_valid = (state_reg == HOLD);
   assign spins_out   = spins_out_reg;

endmodule

// File: tb/tb_spin_readout.sv
// Directed bench for spin_readout (N=4, window 16, two sync stages -> latency 19).
module tb_spin_readout;

   localparam int N   = 4;
   localparam int SB  = 4;
   localparam int SS  = 2;
   localparam int LAT = 19;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         spins_ack;
   logic         ref_in;
   logic [N-1:0] osc_in;
   logic         ready;
   logic         spins_valid;
   logic [N-1:0] spins_out;

   logic         follow;
   logic         toggle_en;
   logic         ref_static;
   logic         ref_tog = 1'b0;
   logic [N-1:0] inv_mask;
   logic [N-1:0] osc_manual;
   int           phase = 0;

   int errors = 0;
   int checks = 0;

   spin_readout #(
      .N(N),
      .SAMPLE_BITS(SB),
      .SYNC_STAGES(SS)
   ) dut (
      .clk(clk),
      .rst(rst),
      .osc_in(osc_in),
      .ref_in(ref_in),
      .start(start),
      .ready(ready),
      .spins_out(spins_out),
      .spins_valid(spins_valid),
      .spins_ack(spins_ack)
   );

   always #5 clk = ~clk;

   assign ref_in = toggle_en ? ref_tog : ref_static;
   assign osc_in = follow ? ({N{ref_in}} ^ inv_mask) : osc_manual;

   // Reference toggles every 3 clocks, changing away from the sampling edge.
   always @(negedge clk) begin
      if (toggle_en) begin
         phase = phase + 1;
         if (phase == 3) begin
            ref_tog = ~ref_tog;
            phase   = 0;
         end
      end
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %-16s got=%0h expected=%0h", tag, got, exp);
      end else begin
         $display("ok   %-16s value=%0h", tag, got);
      end
   endtask

   // Called at a negedge; osc_manual drops to 0 at the negedge after edge E+drop_at.
   task automatic do_readout(input string tag, input logic [N-1:0] exp_spins, input int drop_at);
      int lat;
      lat   = -1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_val({tag, "_busy"}, {31'b0, ready}, 32'd0);
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == drop_at) osc_manual = '0;
         if (spins_valid) begin
            lat = k;
            break;
         end
      end
      check_val({tag, "_lat"}, lat, LAT);
      check_val({tag, "_spins"}, {28'b0, spins_out}, {28'b0, exp_spins});
   endtask

   task automatic do_ack(input string tag);
      spins_ack = 1'b1;
      @(negedge clk);
      spins_ack = 1'b0;
      check_val({tag, "_ackv"}, {31'b0, spins_valid}, 32'd0);
      check_val({tag, "_ackr"}, {31'b0, ready}, 32'd1);
   endtask

   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      spins_ack  = 1'b0;
      follow     = 1'b0;
      toggle_en  = 1'b0;
      ref_static = 1'b0;
      inv_mask   = '0;
      osc_manual = '0;

      // Reset with random inputs
      repeat (3) begin
         @(negedge clk);
         osc_manual = N'($urandom);
         ref_static = 1'($urandom);
         start      = 1'($urandom);
         spins_ack  = 1'($urandom);
      end
      @(negedge clk);
      check_val("rst_ready", {31'b0, ready}, 32'd1);
      check_val("rst_valid", {31'b0, spins_valid}, 32'd0);
      check_val("rst_spins", {28'b0, spins_out}, 32'd0);
      rst        = 1'b0;
      start      = 1'b0;
      spins_ack  = 1'b0;
      ref_static = 1'b0;
      osc_manual = '0;
      @(negedge clk);

      // In-phase: every lane follows the toggling reference
      follow    = 1'b1;
      toggle_en = 1'b1;
      inv_mask  = 4'b0000;
      @(negedge clk);
      do_readout("inphase", 4'b0000, -1);
      do_ack("inphase");

      // Mixed: lanes 0 and 2 anti-phase
      inv_mask = 4'b0101;
      @(negedge clk);
      do_readout("mixed", 4'b0101, -1);

      // Handshake: no ack for 10 cycles while start pulses
      for (int i = 0; i < 10; i++) begin
         start = (i % 2 == 0);
         @(negedge clk);
         check_val("hold_valid", {31'b0, spins_valid}, 32'd1);
         check_val("hold_spins", {28'b0, spins_out}, 32'h5);
         check_val("hold_ready", {31'b0, ready}, 32'd0);
      end
      start     = 1'b1;
      spins_ack = 1'b1;
      @(negedge clk);
      start     = 1'b0;
      spins_ack = 1'b0;
      check_val("ackst_valid", {31'b0, spins_valid}, 32'd0);
      check_val("ackst_ready", {31'b0, ready}, 32'd1);
      check_val("ackst_spins", {28'b0, spins_out}, 32'h5);
      repeat (2) @(negedge clk);
      check_val("no_restart", {31'b0, ready}, 32'd1);

      // Threshold: ref static 0, lane 1 high for a set number of sampled cycles
      follow     = 1'b0;
      toggle_en  = 1'b0;
      ref_static = 1'b0;
      osc_manual = 4'b0010;
      do_readout("thr8", 4'b0000, 8);
      do_ack("thr8");
      osc_manual = 4'b0010;
      do_readout("thr9", 4'b0010, 9);
      do_ack("thr9");
      osc_manual = 4'b0010;
      do_readout("thr16", 4'b0010, -1);
      do_ack("thr16");
      osc_manual = 4'b0000;

      // Reset in the middle of SAMPLE, then a clean all-anti-phase run
      follow    = 1'b1;
      toggle_en = 1'b1;
      inv_mask  = 4'b1111;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_val("midrst_ready", {31'b0, ready}, 32'd1);
      check_val("midrst_valid", {31'b0, spins_valid}, 32'd0);
      check_val("midrst_spins", {28'b0, spins_out}, 32'd0);
      @(negedge clk);
      do_readout("fresh", 4'b1111, -1);
      do_ack("fresh");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
